// File: rtl/mux_rr_arb.sv
// Multi-channel valid/ready mux with manual or round-robin arbitration
// feeding a single registered output slot (full throughput, one word per cycle).
module mux_rr_arb #(
    parameter int WIDTH  = 2,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        select,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0] ch_data [NUM_CH];

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] last_grant_q, last_grant_d;

    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic             accept;
    logic             xfer;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_data[gi]  = in_data[gi*WIDTH +: WIDTH];
            assign in_ready[gi] = xfer && (grant_idx == SEL_W'(gi));
        end
    endgenerate

    // Grant is purely combinational so a request can be served in the cycle it appears.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (!mode) begin
            if ((int'(select) < NUM_CH) && in_valid[select]) begin
                grant_vld = 1'b1;
                grant_idx = select;
            end
        end else begin
            for (int k = 1; k <= NUM_CH; k++) begin
                if (!grant_vld && in_valid[(int'(last_grant_q) + k) % NUM_CH]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'((int'(last_grant_q) + k) % NUM_CH);
                end
            end
        end
    end

    assign accept = !out_valid_q || out_ready;
    assign xfer   = grant_vld && accept && !rst;

    always_comb begin
        out_data_d   = out_data_q;
        out_ch_d     = out_ch_q;
        out_valid_d  = out_valid_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            out_valid_d = grant_vld;
            if (grant_vld) begin
                out_data_d   = ch_data[grant_idx];
                out_ch_d     = grant_idx;
                last_grant_d = grant_idx;
            end
        end
    end

    // Reset leaves last_grant at the top channel so channel 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q   <= '0;
            out_ch_q     <= '0;
            out_valid_q  <= 1'b0;
            last_grant_q <= SEL_W'(NUM_CH - 1);
        end else begin
            out_data_q   <= out_data_d;
            out_ch_q     <= out_ch_d;
            out_valid_q  <= out_valid_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_arb.sv
// Directed and random checks of mux_rr_arb against a cycle-level behavioural
// model of the channel mux (defaults WIDTH=2, NUM_CH=4).
module tb_mux_rr_arb;

    localparam int WIDTH  = 2;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic                    mode;
    logic [SEL_W-1:0]        select;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_ch;
    logic                    out_valid;
    logic                    out_ready;

    int checks   = 0;
    int failures = 0;

    // Model state: the one-word output slot and the last channel served.
    int m_valid = 0;
    int m_data  = 0;
    int m_ch    = 0;
    int m_last  = NUM_CH - 1;

    always #5 clk = ~clk;

    mux_rr_arb #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .select(select),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Which channel the model would serve now, or -1 for none.
    function automatic int model_grant();
        int g;
        g = -1;
        if (mode == 1'b0) begin
            if (int'(select) < NUM_CH && in_valid[select]) g = int'(select);
        end else begin
            for (int k = 1; k <= NUM_CH; k++) begin
                if (g < 0 && in_valid[(m_last + k) % NUM_CH]) g = (m_last + k) % NUM_CH;
            end
        end
        return g;
    endfunction

    // One clock: check in_ready before the edge, advance model, check outputs after.
    task automatic cycle(input string tag);
        int g, acc, exp_rdy, n_valid, n_data, n_ch, n_last;
        #1;
        g   = model_grant();
        acc = (m_valid == 0 || out_ready) ? 1 : 0;
        exp_rdy = (rst == 1'b0 && acc == 1 && g >= 0) ? (1 << g) : 0;
        chk({tag, ".in_ready"}, int'(in_ready), exp_rdy);
        n_valid = m_valid; n_data = m_data; n_ch = m_ch; n_last = m_last;
        if (rst) begin
            n_valid = 0; n_data = 0; n_ch = 0; n_last = NUM_CH - 1;
        end else if (acc == 1) begin
            if (g >= 0) begin
                n_valid = 1; n_ch = g; n_last = g;
                n_data = int'((in_data >> (g * WIDTH)) & ((1 << WIDTH) - 1));
            end else begin
                n_valid = 0;
            end
        end
        @(posedge clk);
        m_valid = n_valid; m_data = n_data; m_ch = n_ch; m_last = n_last;
        #1;
        chk({tag, ".out_valid"}, int'(out_valid), m_valid);
        chk({tag, ".out_data"},  int'(out_data),  m_data);
        chk({tag, ".out_ch"},    int'(out_ch),    m_ch);
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; select = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
        in_data = {2'b11, 2'b10, 2'b01, 2'b00};
        @(posedge clk); #1;
        cycle("reset");
        chk("reset.in_ready_zero", int'(in_ready), 0);

        // Manual select of channel 2
        rst = 1'b0;
        #1;
        chk("manual.in_ready_0100", int'(in_ready), 4'b0100);
        cycle("manual");
        chk("manual.out_data_10", int'(out_data), 2);

        // Round-robin from reset: 0,1,2,3,0 back to back
        rst = 1'b1; cycle("rr_reset");
        rst = 1'b0; mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle("rr_seq");
            chk("rr_seq.ch_const", int'(out_ch), i % NUM_CH);
        end

        // Bring last_grant to 1, then ch1/ch3 alternate with wrap
        in_valid = 4'b0010; cycle("rr_set_last1");
        in_valid = 4'b1010;
        cycle("rr_wrap_a"); chk("rr_wrap.ch3", int'(out_ch), 3);
        cycle("rr_wrap_b"); chk("rr_wrap.ch1", int'(out_ch), 1);

        // Back-pressure for 3 cycles, then release
        in_valid = 4'b1111; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle("hold");
        out_ready = 1'b1;
        cycle("release");

        // Manual select of an idle channel: slot drains, data holds
        mode = 1'b0; select = 2'd1; in_valid = 4'b1101;
        cycle("manual_idle");
        chk("manual_idle.valid_low", int'(out_valid), 0);

        // Reset while holding a word under back-pressure
        mode = 1'b1; in_valid = 4'b1111; cycle("pre_rst_load");
        out_ready = 1'b0; rst = 1'b1; cycle("rst_mid");
        rst = 1'b0; out_ready = 1'b1;
        cycle("post_rst"); chk("post_rst.first_ch0", int'(out_ch), 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 49) == 0);
            mode      = 1'($urandom_range(0, 1));
            select    = SEL_W'($urandom_range(0, NUM_CH - 1));
            in_valid  = NUM_CH'($urandom);
            in_data   = (NUM_CH*WIDTH)'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
